fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Control FSM that sequences instruction fetch around the program counter.
//   Issues a read at the current PC, waits for the memory acknowledge and captures
//   the instruction. Pulses the PC increment, hands the instruction to execute over
//   a valid/ready handshake, then waits for execute-done. Sits between the PC
//   register, instruction memory and the execute stage.
// PARAMETERS
//   ADDR_WIDTH   16  width of pc / mem_addr
//   INSTR_WIDTH  16  width of mem_rdata / instr
//   TIMEOUT      15  max consecutive FETCH cycles without mem_ack before fault (>=1)
//   CNT_WIDTH    16  width of retired_count
// PORTS
//   clk            in   1            rising-edge clock
//   rst            in   1            asynchronous reset, active-high
//   start          in   1            begin fetching (IDLE) / resume (HALT)
//   halt_req       in   1            request stop at next instruction boundary
//   pc             in   ADDR_WIDTH   current PC from the program counter
//   pc_inc         out  1            increment strobe to the program counter
//   mem_req        out  1            instruction read request
//   mem_addr       out  ADDR_WIDTH   read address (= pc while mem_req)
//   mem_ack        in   1            read data valid this cycle
//   mem_rdata      in   INSTR_WIDTH  read data
//   instr          out  INSTR_WIDTH  captured instruction
//   instr_valid    out  1            instr offered to execute
//   instr_ready    in   1            execute accepts instr
//   exec_done      in   1            execute finished current instr
//   busy           out  1            state is FETCH, ISSUE or EXEC
//   halted         out  1            state is HALT
//   fault          out  1            state is FAULT (sticky until rst)
//   retired_count  out  CNT_WIDTH    instructions completed, wraps to 0
// BEHAVIOUR
//   - rst (async): state=IDLE; instr=0, retired_count=0, halt_pending=0, wait_cnt=0.
//     All strobes/flags are 0. rst mid-operation aborts immediately; no pc_inc is issued.
//   - IDLE: start -> FETCH. halt_req is ignored and not latched.
//   - FETCH: mem_req=1, mem_addr=pc (combinational). mem_ack: instr<=mem_rdata,
//     pc_inc=1 for exactly this cycle, -> ISSUE. No ack: wait_cnt++. Ack absent
//     TIMEOUT consecutive cycles -> FAULT. Ack in the cycle wait_cnt==TIMEOUT-1 wins.
//     wait_cnt clears on each FETCH entry.
//   - ISSUE: instr_valid=1, instr held stable. instr_ready -> EXEC. No timeout.
//   - EXEC: exec_done -> retired_count++ (wrap). Then halt_pending ? HALT : FETCH.
//     exec_done outside EXEC is ignored. instr_ready outside ISSUE is ignored.
//   - halt_req latches halt_pending in FETCH/ISSUE/EXEC. It acts only at EXEC exit,
//     so an in-flight instruction always completes.
//   - HALT: halted=1. start clears halt_pending, -> FETCH. halt_req is held off.
//     Simultaneous start+halt_req in HALT: resume, pending stays clear.
//   - FAULT: fault=1. Stays until rst. start/halt_req ignored.
//   - Latency: start@t -> mem_req@t+1. ack@k -> instr_valid and new pc@k+1.
//     ready@r -> EXEC@r+1. done@d -> mem_req@d+1. Zero-wait loop = 3 cycles/instr.
//   - Registered outputs: instr, retired_count. Decoded from state: mem_req,
//     instr_valid, busy, halted, fault. Combinational: pc_inc = FETCH & mem_ack.
// STRUCTURE
//   - Shared header fetch_defs.vh holds the state encodings: IDLE=3'd0, FETCH=3'd1,
//     ISSUE=3'd2, EXEC=3'd3, HALT=3'd4, FAULT=3'd5. Also the 3-bit state width.
//   - Sub-module wait_timer: clear/enable counter of width $clog2(TIMEOUT+1).
//     Outputs expired. Used for the FETCH timeout.
//   - The PC register lives outside; this block only drives pc_inc.
// TESTING
//   1 rst, start@1, ack with zero wait, ready and done immediate, pc=0 -> mem_addr 0,1,2
//     on consecutive fetches. One pc_inc per instr. retired_count 3 after 9 cycles.
//   2 ack delayed 4 cycles -> mem_req held 5 cycles, single pc_inc, instr=mem_rdata
//     (0xBEEF), no fault.
//   3 TIMEOUT=15, no ack -> fault rises exactly 15 cycles after FETCH entry. start and
//     halt_req ignored. rst returns to IDLE with all outputs 0.
//   4 halt_req pulse during ISSUE -> instr completes, retired_count+1, HALT.
//     start -> FETCH at next pc.
//   5 instr_ready low 6 cycles -> instr_valid and instr stable for 6 cycles, no
//     pc_inc. exec_done pulses during ISSUE are ignored.
//   6 rst asserted mid-FETCH with ack high -> immediate IDLE, no pc_inc.
//     retired_count 0xFFFF + 1 -> 0x0000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`timescale 1ns/1ps
// Package: fetch_sequencer_pkg
// Purpose: shared definitions for the instruction fetch sequencer. Holds the
//          state width, the state encodings, and a helper that tells whether
//          a state carries an instruction in flight.
package fetch_sequencer_pkg;

  localparam int STATE_W = 3;

  // The encodings are fixed so that other blocks and debug tools can decode
  // the state bus directly.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // True while an instruction is being fetched, issued or executed.
  function automatic logic in_flight(input state_e s);
    return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/fetch_sequencer_wait.sv
`timescale 1ns/1ps
// Module: wait_timer
// Purpose: counts consecutive enabled cycles. It flags 'expired' while the
//          count is at TIMEOUT-1, which is the last cycle a caller may still
//          be satisfied before it declares a timeout.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   clear    in   return the count to zero (has priority over enable)
//   enable   in   count this cycle
//   expired  out  count has reached TIMEOUT-1
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// Module: fetch_sequencer
// Purpose: control FSM that fetches an instruction at the current PC, hands it
//          to execute over a valid/ready handshake, waits for execute-done and
//          then fetches the next one. Supports halting at an instruction
//          boundary and faults when memory never acknowledges.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-high
//   start          in   begin fetching (IDLE) / resume (HALT)
//   halt_req       in   stop at the next instruction boundary
//   pc             in   current PC from the external program counter
//   pc_inc         out  increment strobe to the program counter
//   mem_req        out  instruction read request
//   mem_addr       out  read address (pc while mem_req, else 0)
//   mem_ack        in   read data valid this cycle
//   mem_rdata      in   read data
//   instr          out  captured instruction
//   instr_valid    out  instruction offered to execute
//   instr_ready    in   execute accepts the instruction
//   exec_done      in   execute finished the current instruction
//   busy           out  in FETCH, ISSUE or EXEC
//   halted         out  in HALT
//   fault          out  in FAULT (sticky until rst)
//   retired_count  out  completed instructions, wraps to 0
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   pc_inc,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   exec_done,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_WIDTH-1:0]   retired_count
);

  state_e state, state_nxt;
  logic   halt_pending, halt_pending_nxt;
  logic   capture;
  logic   retire;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_expired;

  // The timer only runs across consecutive ack-less FETCH cycles; being
  // anywhere else (or getting an ack) holds it at zero, so every FETCH entry
  // starts from a clean count.
  assign timer_en    = (state == ST_FETCH) && !mem_ack;
  assign timer_clear = !timer_en;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      halt_pending  <= 1'b0;
      instr         <= '0;
      retired_count <= '0;
    end else begin
      state        <= state_nxt;
      halt_pending <= halt_pending_nxt;
      if (capture) begin
        instr <= mem_rdata;
      end
      if (retire) begin
        retired_count <= retired_count + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt        = state;
    halt_pending_nxt = halt_pending;
    pc_inc           = 1'b0;
    capture          = 1'b0;
    retire           = 1'b0;

    // A halt request is remembered only while an instruction is in flight;
    // IDLE, HALT and FAULT drop it on the floor.
    if (in_flight(state) && halt_req) begin
      halt_pending_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // An ack in the final allowed cycle beats the timeout.
        if (mem_ack) begin
          pc_inc    = 1'b1;
          capture   = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (timer_expired) begin
          state_nxt = ST_FAULT;
        end
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // The pending halt is only consulted here, so the instruction in
        // flight always finishes before the sequencer stops.
        if (exec_done) begin
          retire    = 1'b1;
          state_nxt = halt_pending ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        // Resuming clears the pending halt even if halt_req is high in the
        // same cycle, so the sequencer does not bounce straight back.
        if (start) begin
          halt_pending_nxt = 1'b0;
          state_nxt        = ST_FETCH;
        end
      end

      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_req     = (state == ST_FETCH);
  assign mem_addr    = mem_req ? pc : '0;
  assign instr_valid = (state == ST_ISSUE);
  assign busy        = in_flight(state);
  assign halted      = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);

endmodule
